// File: rtl/font_glyph_streamer_pkg.sv
// rtl/font_glyph_streamer_pkg.sv - shared font geometry constants and streamer state encoding
package font_pkg;

   localparam int GLYPH_ROWS = 16;
   localparam int GLYPH_COLS = 8;
   localparam int CHAR_W     = 7;
   localparam int FONT_AW    = 14;
   localparam int ROW_W      = $clog2(GLYPH_ROWS);
   localparam int COL_W      = $clog2(GLYPH_COLS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_EMIT
   } stream_state_t;

   function automatic logic [GLYPH_COLS-1:0] bit_reverse(input logic [GLYPH_COLS-1:0] d);
      logic [GLYPH_COLS-1:0] r;
      for (int i = 0; i < GLYPH_COLS; i++) begin
         r[i] = d[GLYPH_COLS-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/font_glyph_streamer_if.sv
// rtl/font_glyph_streamer_if.sv - glyph request and row output handshakes
interface font_glyph_streamer_if;
   import font_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [CHAR_W-1:0] req_char;
   logic              req_inv;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_data;
   logic              out_last;

   modport master (
      output req_valid, req_char, req_inv, out_ready,
      input  req_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  req_valid, req_char, req_inv, out_ready,
      output req_ready, out_valid, out_data, out_last
   );

endinterface

// File: rtl/font_glyph_streamer.sv
// rtl/font_glyph_streamer.sv - reads a 8x16 glyph bit-serially from font ROM and streams it row by row
module font_glyph_streamer
   import font_pkg::*;
#(
   parameter int REVERSE_BITS = 0
) (
   input  logic                clk,
   input  logic                reset_n,
   font_glyph_streamer_if.slave bus,
   output logic                busy,
   output logic [FONT_AW-1:0]  rom_ad,
   output logic                rom_ce,
   output logic                rom_oce,
   input  logic                rom_dout
);

   stream_state_t         state;
   logic [CHAR_W-1:0]     chr;
   logic                  inv;
   logic [ROW_W-1:0]      row;
   logic [COL_W-1:0]      col;
   logic [GLYPH_COLS-1:0] shift;
   logic [GLYPH_COLS-1:0] row_pix;

   assign rom_oce = 1'b1;

   // Shift register only changes outside EMIT, so the row stays stable under backpressure.
   assign row_pix      = shift ^ {GLYPH_COLS{inv}};
   assign bus.out_data = (REVERSE_BITS != 0) ? bit_reverse(row_pix) : row_pix;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         chr           <= '0;
         inv           <= 1'b0;
         row           <= '0;
         col           <= '0;
         shift         <= '0;
         busy          <= 1'b0;
         rom_ad        <= '0;
         rom_ce        <= 1'b0;
         bus.req_ready <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_last  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               bus.req_ready <= 1'b1;
               if (bus.req_valid && bus.req_ready) begin
                  chr           <= bus.req_char;
                  inv           <= bus.req_inv;
                  row           <= '0;
                  col           <= '0;
                  rom_ad        <= {bus.req_char, ROW_W'(0), COL_W'(0)};
                  rom_ce        <= 1'b1;
                  busy          <= 1'b1;
                  bus.req_ready <= 1'b0;
                  state         <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               // ROM data lags the address by one cycle: this cycle carries column col-1.
               if (col != '0) begin
                  shift[col - COL_W'(1)] <= rom_dout;
               end
               col <= col + COL_W'(1);
               if (col == COL_W'(GLYPH_COLS - 1)) begin
                  rom_ce <= 1'b0;
                  state  <= ST_DRAIN;
               end else begin
                  rom_ad <= {chr, row, col + COL_W'(1)};
               end
            end
            ST_DRAIN: begin
               shift[GLYPH_COLS-1] <= rom_dout;
               bus.out_valid       <= 1'b1;
               bus.out_last        <= (row == ROW_W'(GLYPH_ROWS - 1));
               state               <= ST_EMIT;
            end
            ST_EMIT: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.out_last  <= 1'b0;
                  if (row == ROW_W'(GLYPH_ROWS - 1)) begin
                     busy          <= 1'b0;
                     bus.req_ready <= 1'b1;
                     state         <= ST_IDLE;
                  end else begin
                     row    <= row + ROW_W'(1);
                     col    <= '0;
                     rom_ad <= {chr, row + ROW_W'(1), COL_W'(0)};
                     rom_ce <= 1'b1;
                     state  <= ST_FETCH;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_font_glyph_streamer.sv
// tb/tb_font_glyph_streamer.sv - self-checking bench for font_glyph_streamer
module tb_font_glyph_streamer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        busy_m, busy_r;
   logic [13:0] rom_ad_m, rom_ad_r;
   logic        rom_ce_m, rom_ce_r;
   logic        rom_oce_m, rom_oce_r;
   logic        rom_dout_m = 1'b0;
   logic        rom_dout_r = 1'b0;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          lim;
   logic [13:0] max_ad;
   logic [7:0]  got_m [16];
   logic [7:0]  got_r [16];

   logic [7:0] glyph_41 [16] = '{8'h00, 8'h00, 8'h00, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hC6,
                                 8'hFE, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00};
   logic [7:0] glyph_7f [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h38, 8'h6C,
                                 8'hC6, 8'h82, 8'h82, 8'h82, 8'hFE, 8'h00, 8'h00, 8'h00};

   typedef struct {
      logic [6:0] ch;
      logic       inv;
      int         row;
      logic [7:0] exp_data;
      logic [7:0] exp_rev;
   } vec_t;
   vec_t vecs [$];

   font_glyph_streamer_if ifm ();
   font_glyph_streamer_if ifr ();

   assign ifr.req_valid = ifm.req_valid;
   assign ifr.req_char  = ifm.req_char;
   assign ifr.req_inv   = ifm.req_inv;
   assign ifr.out_ready = ifm.out_ready;

   font_glyph_streamer #(.REVERSE_BITS(0)) u_dut (
      .clk(clk), .reset_n(reset_n), .bus(ifm.slave), .busy(busy_m),
      .rom_ad(rom_ad_m), .rom_ce(rom_ce_m), .rom_oce(rom_oce_m), .rom_dout(rom_dout_m)
   );

   font_glyph_streamer #(.REVERSE_BITS(1)) u_dut_rev (
      .clk(clk), .reset_n(reset_n), .bus(ifr.slave), .busy(busy_r),
      .rom_ad(rom_ad_r), .rom_ce(rom_ce_r), .rom_oce(rom_oce_r), .rom_dout(rom_dout_r)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Font content: column c of a row is bit c of the row byte (leftmost pixel = bit 0).
   function automatic logic [7:0] font_row(input logic [6:0] ch, input int r);
      if (ch == 7'h41) return glyph_41[r];
      if (ch == 7'h7F) return glyph_7f[r];
      return 8'((int'(ch) * 29 + r * 13) ^ 'h5A);
   endfunction

   function automatic logic font_bit(input logic [13:0] ad);
      logic [7:0] rw;
      rw = font_row(ad[13:7], int'(ad[6:3]));
      return rw[ad[2:0]];
   endfunction

   function automatic logic [7:0] expect_row(input logic [6:0] ch, input logic inv, input int r, input bit rev);
      logic [7:0] d, o;
      d = font_row(ch, r) ^ {8{inv}};
      o = d;
      if (rev) for (int i = 0; i < 8; i++) o[i] = d[7-i];
      return o;
   endfunction

   // Font ROM models in bypass mode: data follows the sampled address after the edge.
   always @(posedge clk) if (rom_ce_m) rom_dout_m <= font_bit(rom_ad_m);
   always @(posedge clk) if (rom_ce_r) rom_dout_r <= font_bit(rom_ad_r);

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, ifm.out_valid, 0);
      check({tag, "_out_data"}, ifm.out_data, 0);
      check({tag, "_out_last"}, ifm.out_last, 0);
      check({tag, "_busy"}, busy_m, 0);
      check({tag, "_rom_ce"}, rom_ce_m, 0);
      check({tag, "_rom_ad"}, rom_ad_m, 0);
      check({tag, "_rom_oce"}, rom_oce_m, 1);
      check({tag, "_rev_out_data"}, ifr.out_data, 0);
   endtask

   // Called on a negedge with the DUT idle; returns on the negedge after the final handshake.
   task automatic run_glyph(input logic [6:0] ch, input logic inv, input int stall_row,
                            input int stall_len, input bit rnd_ready, input bit noise);
      int r, held, wait_n, t0, last_hs, tot_stall, ce_cnt;
      logic [7:0] prev_data;
      logic       prev_last;
      r = 0; held = 0; wait_n = 0; tot_stall = 0; ce_cnt = 0;
      prev_data = '0; prev_last = 1'b0; max_ad = '0;
      ifm.req_char = ch; ifm.req_inv = inv; ifm.req_valid = 1'b1;
      while (!ifm.req_ready && wait_n < 300) begin @(negedge clk); wait_n++; end
      check("accept_ready", ifm.req_ready, 1);
      t0 = cyc + 1;
      last_hs = t0;
      @(negedge clk);
      ifm.req_valid = 1'b0;
      check("busy_after_accept", busy_m, 1);
      wait_n = 0;
      while (r < 16 && wait_n < 3000) begin
         if (rom_ce_m) begin
            ce_cnt++;
            if (rom_ad_m > max_ad) max_ad = rom_ad_m;
         end
         if (noise) begin
            ifm.req_valid = 1'($urandom_range(0, 1));
            ifm.req_char  = 7'($urandom);
            ifm.req_inv   = 1'($urandom);
         end
         if (ifm.out_valid) begin
            if (held == 0) begin
               check($sformatf("row_latency ch%02h r%0d", ch, r), cyc - last_hs, 9);
               check($sformatf("out_last ch%02h r%0d", ch, r), ifm.out_last, r == 15);
            end else begin
               check("stall_data", ifm.out_data, prev_data);
               check("stall_last", ifm.out_last, prev_last);
               check("stall_rom_ce", rom_ce_m, 0);
            end
            prev_data = ifm.out_data;
            prev_last = ifm.out_last;
            if (r == stall_row && held < stall_len) ifm.out_ready = 1'b0;
            else if (rnd_ready) ifm.out_ready = 1'($urandom_range(0, 1));
            else ifm.out_ready = 1'b1;
            if (ifm.out_ready) begin
               got_m[r] = ifm.out_data;
               got_r[r] = ifr.out_data;
               last_hs = cyc + 1;
               r++;
               held = 0;
            end else begin
               held++;
               tot_stall++;
            end
         end else if (rnd_ready) begin
            ifm.out_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         wait_n++;
      end
      if (r < 16) check("row_timeout", r, 16);
      check("glyph_cycles", last_hs - t0, 160 + tot_stall);
      check("rom_ce_cycles", ce_cnt, 128);
      check("idle_busy", busy_m, 0);
      check("idle_req_ready", ifm.req_ready, 1);
      check("idle_out_valid", ifm.out_valid, 0);
      ifm.req_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("row ch%02h inv%0d r%0d", ch, inv, i), got_m[i], expect_row(ch, inv, i, 0));
         check($sformatf("row_rev ch%02h inv%0d r%0d", ch, inv, i), got_r[i], expect_row(ch, inv, i, 1));
      end
   endtask

   initial begin
      logic [6:0] cur_ch;
      logic       cur_inv;
      bit         loaded;

      vecs.push_back('{7'h41, 1'b0, 0,  8'h00, 8'h00});
      vecs.push_back('{7'h41, 1'b0, 3,  8'h38, 8'h1C});
      vecs.push_back('{7'h41, 1'b0, 4,  8'h6C, 8'h36});
      vecs.push_back('{7'h41, 1'b0, 8,  8'hFE, 8'h7F});
      vecs.push_back('{7'h41, 1'b0, 12, 8'hC6, 8'h63});
      vecs.push_back('{7'h41, 1'b0, 15, 8'h00, 8'h00});
      vecs.push_back('{7'h41, 1'b1, 0,  8'hFF, 8'hFF});
      vecs.push_back('{7'h41, 1'b1, 3,  8'hC7, 8'hE3});
      vecs.push_back('{7'h41, 1'b1, 8,  8'h01, 8'h80});
      vecs.push_back('{7'h7F, 1'b0, 5,  8'h10, 8'h08});
      vecs.push_back('{7'h7F, 1'b0, 6,  8'h38, 8'h1C});
      vecs.push_back('{7'h7F, 1'b0, 9,  8'h82, 8'h41});
      vecs.push_back('{7'h7F, 1'b0, 12, 8'hFE, 8'h7F});

      ifm.req_valid = 1'b0; ifm.req_char = '0; ifm.req_inv = 1'b0; ifm.out_ready = 1'b1;
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("req_ready_after_release", ifm.req_ready, 1);

      loaded = 1'b0; cur_ch = '0; cur_inv = 1'b0;
      foreach (vecs[k]) begin
         if (!loaded || vecs[k].ch != cur_ch || vecs[k].inv != cur_inv) begin
            run_glyph(vecs[k].ch, vecs[k].inv, -1, 0, 1'b0, 1'b0);
            cur_ch = vecs[k].ch; cur_inv = vecs[k].inv; loaded = 1'b1;
         end
         check($sformatf("vec%0d data", k), got_m[vecs[k].row], vecs[k].exp_data);
         check($sformatf("vec%0d rev", k), got_r[vecs[k].row], vecs[k].exp_rev);
      end
      check("max_rom_ad", max_ad, 14'h3FFF);

      run_glyph(7'h41, 1'b0, 4, 5, 1'b0, 1'b0);
      check("stall_row4", got_m[4], 8'h6C);
      check("stall_row5", got_m[5], 8'hC6);

      ifm.req_char = 7'h41; ifm.req_inv = 1'b0; ifm.req_valid = 1'b1; ifm.out_ready = 1'b1;
      lim = 0;
      while (!ifm.req_ready && lim < 300) begin @(negedge clk); lim++; end
      @(negedge clk);
      ifm.req_valid = 1'b0;
      lim = 0;
      while (!(rom_ce_m && rom_ad_m[6:3] == 4'd7) && lim < 300) begin @(negedge clk); lim++; end
      check("reach_row7_fetch", rom_ad_m[6:3], 7);
      reset_n = 1'b0;
      #1 check_reset_outputs("mid_reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_reset_out_valid", ifm.out_valid, 0);
         check("post_reset_busy", busy_m, 0);
      end
      run_glyph(7'h41, 1'b0, -1, 0, 1'b0, 1'b0);

      for (int g = 0; g < 6; g++) begin
         run_glyph(7'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 1'b1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/font_glyph_streamer.md
FONT_GLYPH_STREAMER -- requirements
Module: font_glyph_streamer

Interface
REQ-001 Parameter: REVERSE_BITS, default 0, meaning 0 puts the leftmost pixel in out_data[0] and 1 puts it in out_data[7].
REQ-002 Port: clk  in  1  single clock; every register is on its rising edge.
REQ-003 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  in  1  glyph request strobe.
REQ-005 Port: req_ready  out  1  high only in IDLE.
REQ-006 Port: req_char  in  7  character code, 0x00..0x7F.
REQ-007 Port: req_inv  in  1  reverse-video flag.
REQ-008 Port: out_valid  out  1  a glyph row is available.
REQ-009 Port: out_ready  in  1  sink accepts the row.
REQ-010 Port: out_data  out  8  glyph row pixels.
REQ-011 Port: out_last  out  1  marks row 15.
REQ-012 Port: busy  out  1  high in any state other than IDLE.
REQ-013 Port: rom_ad  out  14  font ROM address {char[6:0], row[3:0], col[2:0]}.
REQ-014 Port: rom_ce  out  1  font ROM clock enable.
REQ-015 Port: rom_oce  out  1  driven constant 1.
REQ-016 Port: rom_dout  in  1  font ROM data; valid 1 cycle after the address edge (bypass read mode).

Function
REQ-017 FSM states: IDLE, FETCH, DRAIN, EMIT.
REQ-018 IDLE: on req_valid && req_ready, latch char and inv, set row=0 and col=0, go to FETCH.
REQ-019 FETCH: 8 cycles with rom_ce=1 and rom_ad={char,row,col}; col increments 0..7; after col 7, go to DRAIN.
REQ-020 Capture: rom_dout sampled in the cycle after column c is issued goes into shift-register bit c; bit 7 is captured in DRAIN.
REQ-021 DRAIN: rom_ce=0; capture the last bit; go to EMIT.
REQ-022 EMIT: out_valid=1 and out_data = row bits XOR {8{inv}}, bit-reversed if REVERSE_BITS=1.
REQ-023 EMIT: out_last=1 when row==15.
REQ-024 EMIT: on out_valid && out_ready, if row==15 go to IDLE, else increment row, clear col and go to FETCH.
REQ-025 Latency: first out_valid is asserted 9 cycles after request acceptance.
REQ-026 Throughput: with out_ready held high, 10 cycles per row and 160 cycles per glyph.
REQ-027 Backpressure: while out_valid && !out_ready, out_data and out_last are stable, rom_ce=0, and no state changes.
REQ-028 req_valid outside IDLE is ignored; no request is accepted in the same cycle as the final-row handshake; the earliest next acceptance is the following cycle.
REQ-029 Address range: char 0x7F, row 15, col 7 gives rom_ad=0x3FFF; no wrap or carry into other fields.
REQ-030 rom_ad holds its last value when rom_ce=0.

Reset
REQ-031 While reset_n=0, asynchronously: state=IDLE, row=0, col=0, shift register=0, char=0, inv=0.
REQ-032 While reset_n=0, outputs are out_valid=0, out_data=0, out_last=0, busy=0, rom_ce=0, rom_ad=0, rom_oce=1.
REQ-033 req_ready=1 from the first edge after reset release.
REQ-034 Reset mid-glyph abandons the glyph; no partial row is emitted after release.

Structure
REQ-035 Shared package font_pkg holds: GLYPH_ROWS=16, GLYPH_COLS=8, CHAR_W=7, FONT_AW=14, and the streamer state enum.
REQ-036 No sub-module: the font ROM is instantiated at top level so it can be shared, and the shift/pack logic stays inline.

Verification
REQ-037 Char 0x41, inv=0, out_ready=1 -> rows 00,00,00,38,6C,C6,C6,C6,FE,C6,C6,C6,C6,00,00,00; out_last only on the 16th row; first out_valid 9 cycles after accept; 160 cycles total.
REQ-038 Char 0x41, inv=1 -> row 3=C7, row 8=01, row 0=FF.
REQ-039 Char 0x41, REVERSE_BITS=1 -> row 3=1C, row 4=36.
REQ-040 Char 0x41, out_ready low for 5 cycles at row 4 -> 6C held stable, rom_ce=0 throughout the stall, row 5 (C6) follows the handshake.
REQ-041 Char 0x7F -> rows 00,00,00,00,00,10,38,6C,C6,82,82,82,FE,00,00,00; maximum rom_ad is 0x3FFF.
REQ-042 Reset in FETCH of row 7 -> all outputs go to reset values immediately; a new request for 0x41 after release streams cleanly from row 0.
